// File: rtl/cpu16_pkg.sv
// Shared opcode constants and sequencer state type for the 16-bit CPU.
// The control decoder imports the same opcode constants.
package cpu16_pkg;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_HALT  = 6'b111111;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      ISSUE   = 2'd1,
      RESOLVE = 2'd2,
      HALTED  = 2'd3
   } seq_state_t;

   // halt_opc is passed in so a retargeted HALT encoding stays legal
   function automatic logic opc_known(input logic [5:0] opc, input logic [5:0] halt_opc);
      return (opc == OPC_RTYPE) || (opc == OPC_LW) || (opc == OPC_SW) ||
             (opc == OPC_BEQ) || (opc == halt_opc);
   endfunction

endpackage

// File: rtl/instr_fetch_seq.sv
// Instruction fetch/issue sequencer: owns the PC, fetches over req/ack,
// issues one instruction at a time and waits for resolution before refetch.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   FETCH   | imem_req high at pc, waiting for imem_ack
//   ISSUE   | instr_valid high, holding instruction until issue_ready
//   RESOLVE | waiting for resolve_valid to compute the next pc
//   HALTED  | HALT issued, no further fetches until reset
module instr_fetch_seq
   import cpu16_pkg::*;
#(
   parameter int               ADDR_W   = 16,
   parameter int               INSTR_W  = 16,
   parameter int               OFF_W    = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [5:0]        HALT_OPC = OPC_HALT
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               issue_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [5:0]         opcode,
   output logic [ADDR_W-1:0]  pc_out,
   input  logic               resolve_valid,
   input  logic               branch,
   input  logic               zero,
   output logic               illegal,
   output logic               halted
);

   seq_state_t        state, state_d;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] off_bytes;
   logic [OFF_W-1:0]  offset;
   logic              load_instr;
   logic              load_pc;

   assign opcode      = instr[INSTR_W-1 -: 6];
   assign offset      = instr[OFF_W-1:0];
   assign imem_addr   = pc;
   assign pc_out      = pc;
   assign instr_valid = (state == ISSUE);
   assign halted      = (state == HALTED);

   // Offset counts instructions; sign-extend before scaling to bytes
   assign off_bytes = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset} << 1;
   assign pc_next   = (branch && zero) ? (pc + ADDR_W'(2) + off_bytes)
                                       : (pc + ADDR_W'(2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         instr    <= '0;
         imem_req <= 1'b0;
      end else begin
         state    <= state_d;
         imem_req <= (state_d == FETCH);
         if (load_instr) instr <= imem_rdata;
         if (load_pc)    pc    <= pc_next;
      end
   end

   // imem_req gates ack acceptance, so the cycle right after reset ignores acks
   always_comb begin
      state_d    = state;
      load_instr = 1'b0;
      load_pc    = 1'b0;
      illegal    = 1'b0;
      case (state)
         FETCH: begin
            if (imem_req && imem_ack) begin
               load_instr = 1'b1;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (issue_ready) begin
               illegal = !opc_known(opcode, HALT_OPC);
               state_d = (opcode == HALT_OPC) ? HALTED : RESOLVE;
            end
         end
         RESOLVE: begin
            if (resolve_valid) begin
               load_pc = 1'b1;
               state_d = FETCH;
            end
         end
         default: state_d = state;
      endcase
   end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: event-level model checked every cycle,
// plus literal expectations on fetch addresses and handshake timing.
module tb_instr_fetch_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic        instr_valid;
   logic        issue_ready = 1'b0;
   logic [15:0] instr;
   logic [5:0]  opcode;
   logic [15:0] pc_out;
   logic        resolve_valid = 1'b0;
   logic        branch = 1'b0;
   logic        zero = 1'b0;
   logic        illegal;
   logic        halted;

   int errors = 0;
   int checks = 0;
   int illegal_count = 0;

   always #5 clk = ~clk;

   instr_fetch_seq dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .issue_ready(issue_ready),
      .instr(instr), .opcode(opcode), .pc_out(pc_out),
      .resolve_valid(resolve_valid), .branch(branch), .zero(zero),
      .illegal(illegal), .halted(halted)
   );

   // ---------------- behavioural model ----------------
   logic [15:0] m_pc = 16'h0000;
   logic [15:0] m_instr = 16'h0000;
   logic        m_req = 1'b0;
   logic        m_valid = 1'b0;
   logic        m_wait = 1'b0;
   logic        m_halted = 1'b0;

   function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [15:0] ins,
                                              input logic br, input logic z);
      int off;
      off = (br && z) ? 2 * int'($signed(ins[7:0])) : 0;
      return 16'((int'(pc) + 2 + off) & 32'hFFFF);
   endfunction

   function automatic logic model_illegal(input logic [15:0] ins);
      logic [5:0] opc;
      opc = ins[15:10];
      return !(opc inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h3F});
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= 16'h0000; m_instr <= '0; m_req <= 1'b0;
         m_valid <= 1'b0; m_wait <= 1'b0; m_halted <= 1'b0;
      end else if (m_req && imem_ack) begin
         m_instr <= imem_rdata; m_req <= 1'b0; m_valid <= 1'b1;
      end else if (m_valid && issue_ready) begin
         m_valid <= 1'b0;
         if (m_instr[15:10] == 6'h3F) m_halted <= 1'b1;
         else                         m_wait   <= 1'b1;
      end else if (m_wait && resolve_valid) begin
         m_wait <= 1'b0;
         m_pc   <= model_next(m_pc, m_instr, branch, zero);
         m_req  <= 1'b1;
      end else if (!m_req && !m_valid && !m_wait && !m_halted) begin
         m_req <= 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("m_imem_req", imem_req, m_req);
      if (m_req) check("m_imem_addr", imem_addr, m_pc);
      check("m_instr_valid", instr_valid, m_valid);
      if (m_valid) begin
         check("m_instr", instr, m_instr);
         check("m_opcode", opcode, m_instr[15:10]);
         check("m_pc_out", pc_out, m_pc);
      end
      check("m_illegal", illegal, m_valid && issue_ready && model_illegal(m_instr));
      check("m_halted", halted, m_halted);
      if (illegal) illegal_count++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 50) begin step(); n++; end
      check("req_timeout", imem_req, 1'b1);
   endtask

   task automatic do_fetch(input logic [15:0] exp_addr, input logic [15:0] data, input int waits);
      wait_req();
      check("fetch_addr", imem_addr, exp_addr);
      repeat (waits) step();
      imem_rdata = data; imem_ack = 1'b1;
      step();
      imem_ack = 1'b0; imem_rdata = 16'hDEAD;
      check("valid_after_ack", instr_valid, 1'b1);
      check("instr_captured", instr, data);
      check("pc_out", pc_out, exp_addr);
   endtask

   task automatic do_issue(input int stall, input logic exp_ill);
      repeat (stall) step();
      issue_ready = 1'b1; #1;
      check("illegal_pulse", illegal, exp_ill);
      step();
      issue_ready = 1'b0;
      check("valid_drops", instr_valid, 1'b0);
   endtask

   task automatic do_resolve(input logic br, input logic z, input logic [15:0] exp_next);
      step();
      resolve_valid = 1'b1; branch = br; zero = z;
      step();
      resolve_valid = 1'b0; branch = 1'b0; zero = 1'b0;
      check("next_req", imem_req, 1'b1);
      check("next_addr", imem_addr, exp_next);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      check("rst_req", imem_req, 1'b0);
      check("rst_valid", instr_valid, 1'b0);
      check("rst_instr", instr, 16'h0000);
      check("rst_halted", halted, 1'b0);
      rst_n = 1'b1;
      check("req_before_edge", imem_req, 1'b0);
      step();
      check("req_first_edge", imem_req, 1'b1);

      // R-type with ready held high across the fetch
      issue_ready = 1'b1;
      do_fetch(16'h0000, 16'h0000, 2);
      check("opcode_rtype", opcode, 6'b000000);
      step();
      issue_ready = 1'b0;
      do_resolve(1'b0, 1'b1, 16'h0002);

      do_fetch(16'h0002, 16'h1006, 1); do_issue(0, 1'b0); do_resolve(1'b1, 1'b1, 16'h0010);
      do_fetch(16'h0010, 16'h1005, 0); do_issue(1, 1'b0); do_resolve(1'b1, 1'b0, 16'h0012);
      do_fetch(16'h0012, 16'h10FE, 2); do_issue(0, 1'b0); do_resolve(1'b1, 1'b1, 16'h0010);
      do_fetch(16'h0010, 16'h1005, 1); do_issue(0, 1'b0); do_resolve(1'b1, 1'b1, 16'h001C);
      do_fetch(16'h001C, 16'h10F3, 0); do_issue(2, 1'b0); do_resolve(1'b1, 1'b1, 16'h0004);
      do_fetch(16'h0004, 16'h10FE, 1); do_issue(0, 1'b0); do_resolve(1'b1, 1'b1, 16'h0002);
      do_fetch(16'h0002, 16'h10FD, 0); do_issue(0, 1'b0); do_resolve(1'b1, 1'b1, 16'hFFFE);
      do_fetch(16'hFFFE, 16'h1005, 3); do_issue(0, 1'b0); do_resolve(1'b1, 1'b0, 16'h0000);

      // stall in ISSUE with stray ack and resolve pulses
      do_fetch(16'h0000, 16'h0123, 1);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin imem_ack = 1'b1; imem_rdata = 16'hFFFF; end
         if (i == 2) begin resolve_valid = 1'b1; branch = 1'b1; zero = 1'b1; end
         step();
         imem_ack = 1'b0; resolve_valid = 1'b0; branch = 1'b0; zero = 1'b0;
         check("stall_valid", instr_valid, 1'b1);
         check("stall_instr", instr, 16'h0123);
         check("stall_pc", pc_out, 16'h0000);
      end
      do_issue(0, 1'b0); do_resolve(1'b0, 1'b0, 16'h0002);

      do_fetch(16'h0002, 16'h5400, 2); do_issue(1, 1'b1); do_resolve(1'b0, 1'b0, 16'h0004);
      check("illegal_once", illegal_count, 1);
      do_fetch(16'h0004, 16'h8C00, 0); do_issue(0, 1'b0); do_resolve(1'b0, 1'b0, 16'h0006);
      do_fetch(16'h0006, 16'hAC00, 1); do_issue(0, 1'b0); do_resolve(1'b0, 1'b0, 16'h0008);

      do_fetch(16'h0008, 16'hFC00, 0); do_issue(0, 1'b0);
      check("halted_set", halted, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step();
         check("halt_no_req", imem_req, 1'b0);
      end

      // reset while imem_req is high, with a late ack across release
      rst_n = 1'b0; #20; step();
      rst_n = 1'b1;
      step();
      check("restart_req", imem_req, 1'b1);
      check("restart_addr", imem_addr, 16'h0000);
      rst_n = 1'b0; #1;
      check("rst_drop_req", imem_req, 1'b0);
      check("rst_drop_halted", halted, 1'b0);
      imem_ack = 1'b1; imem_rdata = 16'hFFFF;
      step(); step();
      rst_n = 1'b1;
      step();
      imem_ack = 1'b0;
      check("late_ack_ignored", instr_valid, 1'b0);
      check("late_ack_instr", instr, 16'h0000);

      // reset while waiting in RESOLVE
      do_fetch(16'h0000, 16'h8C00, 0); do_issue(0, 1'b0);
      step();
      rst_n = 1'b0; #1;
      check("rst_resolve_req", imem_req, 1'b0);
      check("rst_resolve_valid", instr_valid, 1'b0);
      check("rst_resolve_instr", instr, 16'h0000);
      step();
      rst_n = 1'b1;
      do_fetch(16'h0000, 16'h0000, 1); do_issue(0, 1'b0); do_resolve(1'b0, 1'b0, 16'h0002);

      check("illegal_total", illegal_count, 1);
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
